regfile_wb_arbiter: RTL and testbench

Write-back arbiter for the 64-bit, 32-entry register file. It shares the file's single write port (`we3`/`wa3`/`wd3`) between NREQ write-back sources, such as ALU, load and multi-cycle units, using a valid/ready handshake. It drives the write port from a registered output stage and drops writes to X31 (XZR) at the arbiter, so no source ever issues a write that reaches the file. It sits between the execution/memory stages and `regfile`.

---
 rtl/regfile_wb_arbiter_if.sv | 17 +
 rtl/regfile_wb_arbiter.sv | 103 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the requesters and the arbiter, plus the registered
// register-file write port the arbiter drives.
interface regfile_wb_arbiter_if #(parameter int NREQ = 3);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [5*NREQ-1:0]    req_addr;
  logic [64*NREQ-1:0]   req_data;
  logic                 we3;
  logic [4:0]           wa3;
  logic [63:0]          wd3;
  logic                 drop_xzr;

  modport master (output req_valid, req_addr, req_data,
                  input  req_ready, we3, wa3, wd3, drop_xzr);
  modport slave  (input  req_valid, req_addr, req_data,
                  output req_ready, we3, wa3, wd3, drop_xzr);
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between NREQ write-back sources.
// WB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise lowest index wins.
module regfile_wb_arbiter #(
  parameter  int NREQ = 3,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  regfile_wb_arbiter_if.slave  bus
);

  logic [NREQ-1:0] gnt_d;
  logic [PW-1:0]   gidx;
  logic            found;
  logic            acc;
  logic [4:0]      addr_g;
  logic [63:0]     data_g;

  logic            we3_q, drop_q;
  logic [4:0]      wa3_q;
  logic [63:0]     wd3_q;

`ifdef WB_ROUND_ROBIN_EN
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW:0]     cand;

  // Search upward from the pointer, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
      if (!found && bus.req_valid[cand[PW-1:0]]) begin
        found = 1'b1;
        gidx  = cand[PW-1:0];
      end
    end
  end
`else
  always_comb begin
    gidx = '0;
    for (int k = NREQ-1; k >= 0; k--)
      if (bus.req_valid[k]) gidx = PW'(k);
    found = |bus.req_valid;
  end
`endif

  // Grant and write-port mux; ready never looks at addr/data.
  always_comb begin
    gnt_d = '0;
    if (found && !flush && !reset) gnt_d[gidx] = 1'b1;
    acc    = |gnt_d;
    addr_g = '0;
    data_g = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_d[i]) begin
        addr_g = bus.req_addr[5*i +: 5];
        data_g = bus.req_data[64*i +: 64];
      end
    end
  end

`ifdef WB_ROUND_ROBIN_EN
  always_comb begin
    ptr_d = ptr_q;
    if (flush)    ptr_d = '0;
    else if (acc) ptr_d = (gidx == PW'(NREQ-1)) ? '0 : gidx + PW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`endif

  // X31 writes are consumed but never reach the file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we3_q  <= 1'b0;
      drop_q <= 1'b0;
      wa3_q  <= '0;
      wd3_q  <= '0;
    end else if (acc) begin
      wa3_q  <= addr_g;
      wd3_q  <= data_g;
      we3_q  <= (addr_g != 5'd31);
      drop_q <= (addr_g == 5'd31);
    end else begin
      we3_q  <= 1'b0;
      drop_q <= 1'b0;
    end
  end

  assign bus.req_ready = gnt_d;
  assign bus.we3       = we3_q;
  assign bus.wa3       = wa3_q;
  assign bus.wd3       = wd3_q;
  assign bus.drop_xzr  = drop_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: grants checked each step, accepted
// writes queued and compared against the write port one cycle later.
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;

  logic clk = 1'b0;
  logic reset, flush;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.NREQ(NREQ)) bus();
  regfile_wb_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus.slave));

  // Plain register file with no X31 special case, so any leaked write shows.
  logic [63:0] rf [32] = '{default: '0};
  always @(posedge clk) if (bus.we3) rf[bus.wa3] <= bus.wd3;

  typedef struct packed { logic [4:0] a; logic [63:0] d; logic drop; } exp_t;
  exp_t q[$];
  int nchk = 0, nfail = 0;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    nchk++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic req(input int i, input logic v, input logic [4:0] a, input logic [63:0] d);
    bus.req_valid[i]         = v;
    bus.req_addr[5*i +: 5]   = a;
    bus.req_data[64*i +: 64] = d;
  endtask

  // Check grant, queue the expected write, cross one edge, check the port.
  task automatic step(input string tag, input logic [NREQ-1:0] exp_rdy);
    exp_t e;
    #1;
    chk({tag, ".rdy"}, 64'(bus.req_ready), 64'(exp_rdy));
    for (int i = 0; i < NREQ; i++)
      if (exp_rdy[i])
        q.push_back('{a: bus.req_addr[5*i +: 5], d: bus.req_data[64*i +: 64],
                      drop: (bus.req_addr[5*i +: 5] == 5'd31)});
    @(posedge clk); #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, ".we3"},  64'(bus.we3),      64'(!e.drop));
      chk({tag, ".wa3"},  64'(bus.wa3),      64'(e.a));
      chk({tag, ".wd3"},  bus.wd3,           e.d);
      chk({tag, ".drop"}, 64'(bus.drop_xzr), 64'(e.drop));
    end else begin
      chk({tag, ".we3"},  64'(bus.we3),      64'(0));
      chk({tag, ".drop"}, 64'(bus.drop_xzr), 64'(0));
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0;
    #1;
    chk("rst.we3",  64'(bus.we3),      64'(0));
    chk("rst.wa3",  64'(bus.wa3),      64'(0));
    chk("rst.wd3",  bus.wd3,           64'(0));
    chk("rst.drop", 64'(bus.drop_xzr), 64'(0));
    req(0, 1'b1, 5'd9, 64'h9);
    #1 chk("rst.rdy", 64'(bus.req_ready), 64'(0));
    req(0, 1'b0, 5'd0, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single write from requester 1, readback two edges later
    req(1, 1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001);
    step("single", 3'b010);
    req(1, 1'b0, 5'd0, 64'h0);
    step("single.idle", 3'b000);
    chk("single.rf5", rf[5], 64'hDEAD_BEEF_0000_0001);

    // Flush with pointer at 2: no grant, then requester 0 wins
    req(0, 1'b1, 5'd10, 64'h100);
    req(2, 1'b1, 5'd12, 64'h102);
    flush = 1'b1;
    step("flush", 3'b000);
    flush = 1'b0;
    step("postflush", 3'b001);
    req(0, 1'b0, 5'd0, 64'h0);
    step("postflush.r2", 3'b100);
    req(2, 1'b0, 5'd0, 64'h0);

    // XZR write is consumed and dropped
    req(0, 1'b1, 5'd31, 64'h55);
    step("xzr", 3'b001);
    req(0, 1'b0, 5'd0, 64'h0);
    step("xzr.idle", 3'b000);
    step("xzr.idle2", 3'b000);
    chk("xzr.rf31", rf[31], 64'h0);

    // Reset mid-cycle while a write sits in the output stage
    req(1, 1'b1, 5'd7, 64'hAAAA);
    step("prerst", 3'b010);
    #2 reset = 1'b1;
    #1;
    chk("midrst.we3",  64'(bus.we3),       64'(0));
    chk("midrst.wa3",  64'(bus.wa3),       64'(0));
    chk("midrst.wd3",  bus.wd3,            64'(0));
    chk("midrst.drop", 64'(bus.drop_xzr),  64'(0));
    chk("midrst.rdy",  64'(bus.req_ready), 64'(0));
    @(posedge clk); #1;
    chk("midrst.rdy2", 64'(bus.req_ready), 64'(0));
    chk("midrst.we3b", 64'(bus.we3),       64'(0));
    reset = 1'b0;
    req(1, 1'b0, 5'd0, 64'h0);
    step("postrst", 3'b000);
    chk("postrst.rf7", rf[7], 64'h0);

`ifdef WB_ROUND_ROBIN_EN
    req(0, 1'b1, 5'd1, 64'h11);
    req(1, 1'b1, 5'd2, 64'h22);
    req(2, 1'b1, 5'd3, 64'h33);
    for (int r = 0; r < 2; r++)
      for (int g = 0; g < NREQ; g++)
        step("rot", NREQ'(1 << g));
    bus.req_valid = '0;
`else
    req(0, 1'b1, 5'd1, 64'h11);
    req(2, 1'b1, 5'd3, 64'h33);
    for (int c = 0; c < 3; c++) step("fixed", 3'b001);
    req(0, 1'b0, 5'd0, 64'h0);
    step("fixed.r2", 3'b100);
    req(2, 1'b0, 5'd0, 64'h0);
`endif
    step("final.idle", 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end
endmodule
